obstacle_spawner: RTL and testbench

//  Consumes the LFSR outputs (rand_a_num, rand_b_num) and places yellow cars in a

---
 rtl/two_cars_pkg.sv | 21 ++
 rtl/slot_alloc.sv | 24 ++
 rtl/obstacle_spawner.sv | 167 ++++++++++++++++
 tb/tb_obstacle_spawner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/two_cars_pkg.sv
// Types and constants shared by the obstacle spawner, the sprite renderer and collision logic.
package two_cars_pkg;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SPAWN,
    PAIR
  } spawner_state_t;

  localparam int unsigned SCREEN_H_DEFAULT = 480;

  // Left x edge of each lane; lanes 0/1 are the left road half, 2/3 the right.
  localparam int unsigned LANE_X0 = 200;
  localparam int unsigned LANE_X1 = 260;
  localparam int unsigned LANE_X2 = 340;
  localparam int unsigned LANE_X3 = 400;

endpackage

// File: rtl/slot_alloc.sv
// Combinational lowest-index free-slot finder.
module slot_alloc #(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0]         valid,
  output logic                         found,
  output logic [$clog2(NUM_SLOTS)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NUM_SLOTS);

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found = 1'b1;
        idx   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Per-frame mover and spawner for yellow cars held in a fixed table of slots.
module obstacle_spawner import two_cars_pkg::*; #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned Y_W       = 10,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEFAULT,
  parameter int unsigned STEP      = 2,
  parameter int unsigned SPAWN_GAP = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [2:0]               rand_a_num,
  input  logic                     rand_b_num,
  output logic [NUM_SLOTS-1:0]     obj_valid,
  output logic [2*NUM_SLOTS-1:0]   obj_lane,
  output logic [Y_W*NUM_SLOTS-1:0] obj_y,
  output logic                     spawn_pulse,
  output logic                     retire_pulse,
  output logic [7:0]               drop_cnt,
  output logic                     busy
);

  localparam int unsigned IdxW = $clog2(NUM_SLOTS);
  localparam int unsigned GapW = $clog2(SPAWN_GAP + 1);
  localparam logic [GapW-1:0] GapFull   = GapW'(SPAWN_GAP);
  localparam logic [Y_W:0]    ScreenLim = (Y_W + 1)'(SCREEN_H);
  localparam logic [Y_W:0]    StepW     = (Y_W + 1)'(STEP);

  spawner_state_t state_q, state_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  lane_t [NUM_SLOTS-1:0] lane_q, lane_d;
  logic [NUM_SLOTS-1:0][Y_W-1:0] y_q, y_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0] drop_q, drop_d;
  logic pair_q, pair_d;
  lane_t plane_q, plane_d;
  logic spawn_q, spawn_d, retire_q, retire_d, busy_q, busy_d;

  logic            free_found;
  logic [IdxW-1:0] free_idx;
  logic [Y_W:0]    ny;

  // valid_q already reflects MOVE (and the first spawn) when SPAWN/PAIR consult it.
  slot_alloc #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_slot_alloc (
    .valid(valid_q),
    .found(free_found),
    .idx  (free_idx)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    lane_d   = lane_q;
    y_d      = y_q;
    gap_d    = gap_q;
    drop_d   = drop_q;
    pair_d   = pair_q;
    plane_d  = plane_q;
    spawn_d  = 1'b0;
    retire_d = 1'b0;
    ny       = '0;
    if (clear) begin
      state_d = IDLE;
      valid_d = '0;
      lane_d  = '0;
      y_d     = '0;
      gap_d   = GapFull;
      pair_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_tick && enable) state_d = MOVE;
        end
        MOVE: begin
          for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (valid_q[i]) begin
              ny = {1'b0, y_q[i]} + StepW;
              if (ny >= ScreenLim) begin
                valid_d[i] = 1'b0;
                y_d[i]     = '0;
                retire_d   = 1'b1;
              end else begin
                y_d[i] = ny[Y_W-1:0];
              end
            end
          end
          if (gap_q != GapFull) gap_d = gap_q + GapW'(1);
          state_d = SPAWN;
        end
        SPAWN: begin
          pair_d = 1'b0;
          if (rand_b_num && gap_q == GapFull) begin
            if (free_found) begin
              valid_d[free_idx] = 1'b1;
              lane_d[free_idx]  = rand_a_num[1:0];
              y_d[free_idx]     = '0;
              spawn_d           = 1'b1;
              gap_d             = '0;
              pair_d            = rand_a_num[2];
              plane_d           = rand_a_num[1:0];
            end else if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end
          state_d = PAIR;
        end
        PAIR: begin
          if (pair_q) begin
            if (free_found) begin
              valid_d[free_idx] = 1'b1;
              lane_d[free_idx]  = plane_q ^ 2'b10;
              y_d[free_idx]     = '0;
              spawn_d           = 1'b1;
            end else if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end
          pair_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      lane_q   <= '0;
      y_q      <= '0;
      gap_q    <= GapFull;
      drop_q   <= '0;
      pair_q   <= 1'b0;
      plane_q  <= '0;
      spawn_q  <= 1'b0;
      retire_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      lane_q   <= lane_d;
      y_q      <= y_d;
      gap_q    <= gap_d;
      drop_q   <= drop_d;
      pair_q   <= pair_d;
      plane_q  <= plane_d;
      spawn_q  <= spawn_d;
      retire_q <= retire_d;
      busy_q   <= busy_d;
    end
  end

  assign obj_valid    = valid_q;
  assign obj_lane     = lane_q;
  assign obj_y        = y_q;
  assign spawn_pulse  = spawn_q;
  assign retire_pulse = retire_q;
  assign drop_cnt     = drop_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench: expected spawns are queued when stimulus is driven, checked on spawn_pulse.
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       clear = 1'b0;
  logic       enable_a = 1'b0;
  logic       enable_b = 1'b0;
  logic [2:0] rand_a = '0;
  logic       rand_b = 1'b0;

  logic [3:0]  valid_a, valid_b;
  logic [7:0]  lane_a, lane_b;
  logic [39:0] y_a, y_b;
  logic        spawn_a, spawn_b, retire_a, retire_b, busy_a, busy_b;
  logic [7:0]  drop_a, drop_b;

  int total = 0;
  int bad = 0;
  logic sel_b = 1'b0;

  typedef struct {
    int         slot;
    logic [1:0] lane;
  } spawn_exp_t;
  spawn_exp_t exp_q[$];

  always #5 clk = ~clk;

  obstacle_spawner u_dut_a (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick), .enable(enable_a), .clear(clear),
    .rand_a_num(rand_a), .rand_b_num(rand_b), .obj_valid(valid_a), .obj_lane(lane_a),
    .obj_y(y_a), .spawn_pulse(spawn_a), .retire_pulse(retire_a), .drop_cnt(drop_a),
    .busy(busy_a)
  );

  // Tall screen and gap of 1 so a full table can absorb 300 drops without retiring.
  obstacle_spawner #(.SPAWN_GAP(1), .SCREEN_H(1000)) u_dut_b (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(frame_tick), .enable(enable_b), .clear(clear),
    .rand_a_num(rand_a), .rand_b_num(rand_b), .obj_valid(valid_b), .obj_lane(lane_b),
    .obj_y(y_b), .spawn_pulse(spawn_b), .retire_pulse(retire_b), .drop_cnt(drop_b),
    .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_spawn(input int slot, input logic [1:0] lane);
    spawn_exp_t e;
    e.slot = slot;
    e.lane = lane;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && spawn_a) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_spawn", 32'd1, 32'd0);
      end else begin
        spawn_exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_valid", 32'(valid_a[e.slot]), 32'd1);
        check_eq("sb_lane", 32'(lane_a[2*e.slot +: 2]), 32'(e.lane));
        check_eq("sb_y", 32'(y_a[10*e.slot +: 10]), 32'd0);
      end
    end
  end

  // One frame: tick at edge k, then sample the pulses after edges k..k+4.
  // clr_at/rst_at pick the iteration in which clear or reset is asserted for one cycle.
  task automatic frame(input int clr_at, input int rst_at,
                       output logic [4:0] sp, output logic [4:0] rt, output logic [4:0] bz);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sp[i] = sel_b ? spawn_b : spawn_a;
      rt[i] = sel_b ? retire_b : retire_a;
      bz[i] = sel_b ? busy_b : busy_a;
      clear = (i == clr_at);
      rst_n = (i != rst_at);
      @(negedge clk);
    end
    clear = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [4:0] sp, rt, bz;
  logic       any_rt;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_lane", 32'(lane_a), 32'd0);
    check_eq("rst_y", y_a[31:0], 32'd0);
    check_eq("rst_spawn", 32'(spawn_a), 32'd0);
    check_eq("rst_retire", 32'(retire_a), 32'd0);
    check_eq("rst_drop", 32'(drop_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);

    // Fill B (pairs in lanes 0/2) then saturate its drop counter; A is paused.
    sel_b = 1'b1;
    enable_b = 1'b1;
    rand_b = 1'b1;
    rand_a = 3'b100;
    frame(-1, -1, sp, rt, bz);
    check_eq("b_first_pair", 32'(sp), 32'b01100);
    frame(-1, -1, sp, rt, bz);
    check_eq("b_full", 32'(valid_b), 32'hF);
    check_eq("b_lanes", 32'(lane_b), 32'b10_00_10_00);
    check_eq("b_drop0", 32'(drop_b), 32'd0);
    any_rt = 1'b0;
    for (int n = 0; n < 300; n++) begin
      frame(-1, -1, sp, rt, bz);
      any_rt = any_rt | (|rt) | (|sp);
    end
    check_eq("b_drop_sat", 32'(drop_b), 32'd255);
    check_eq("b_still_full", 32'(valid_b), 32'hF);
    check_eq("b_no_activity", 32'(any_rt), 32'd0);
    check_eq("a_paused", 32'(valid_a), 32'd0);

    // clear during MOVE on B keeps drop_cnt.
    frame(0, -1, sp, rt, bz);
    check_eq("b_clr_valid", 32'(valid_b), 32'd0);
    check_eq("b_clr_drop", 32'(drop_b), 32'd255);
    check_eq("b_clr_busy", 32'(bz), 32'b00001);
    check_eq("b_clr_spawn", 32'(sp), 32'd0);

    // Single spawn on A, immediately (gap starts full).
    sel_b = 1'b0;
    enable_b = 1'b0;
    enable_a = 1'b1;
    rand_b = 1'b1;
    rand_a = 3'b001;
    push_spawn(0, 2'd1);
    frame(-1, -1, sp, rt, bz);
    check_eq("t2_spawn_hist", 32'(sp), 32'b00100);
    check_eq("t2_busy_hist", 32'(bz), 32'b00111);
    check_eq("t2_valid", 32'(valid_a), 32'b0001);
    rand_b = 1'b0;
    frame(-1, -1, sp, rt, bz);
    check_eq("t2_move_y", 32'(y_a[9:0]), 32'd2);

    // Mirrored pair, then a tick inside the gap.
    clear_pulse();
    check_eq("t3_cleared", 32'(valid_a), 32'd0);
    rand_b = 1'b1;
    rand_a = 3'b110;
    push_spawn(0, 2'd2);
    push_spawn(1, 2'd0);
    frame(-1, -1, sp, rt, bz);
    check_eq("t3_spawn_hist", 32'(sp), 32'b01100);
    check_eq("t3_valid", 32'(valid_a), 32'b0011);
    frame(-1, -1, sp, rt, bz);
    check_eq("t3_gap_block", 32'(sp), 32'd0);
    check_eq("t3_valid_kept", 32'(valid_a), 32'b0011);

    // Drive a car to y=478, then retire it and reuse the slot in the same frame.
    clear_pulse();
    rand_a = 3'b011;
    push_spawn(0, 2'd3);
    frame(-1, -1, sp, rt, bz);
    rand_b = 1'b0;
    for (int n = 0; n < 239; n++) frame(-1, -1, sp, rt, bz);
    check_eq("t4_y478", 32'(y_a[9:0]), 32'd478);
    check_eq("t4_valid_pre", 32'(valid_a), 32'b0001);
    rand_b = 1'b1;
    rand_a = 3'b000;
    push_spawn(0, 2'd0);
    frame(-1, -1, sp, rt, bz);
    check_eq("t4_retire_hist", 32'(rt), 32'b00010);
    check_eq("t4_reuse_hist", 32'(sp), 32'b00100);
    check_eq("t4_valid", 32'(valid_a), 32'b0001);
    check_eq("t4_lane", 32'(lane_a[1:0]), 32'd0);

    // clear during MOVE on A: no spawn, table empty.
    frame(0, -1, sp, rt, bz);
    check_eq("t6_clr_spawn", 32'(sp), 32'd0);
    check_eq("t6_clr_valid", 32'(valid_a), 32'd0);
    check_eq("t6_clr_busy", 32'(busy_a), 32'd0);

    // Reset while A is in SPAWN.
    frame(-1, 1, sp, rt, bz);
    check_eq("t6_rst_spawn", 32'(sp), 32'd0);
    check_eq("t6_rst_valid", 32'(valid_a), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_a), 32'd0);
    check_eq("t6_rst_drop_a", 32'(drop_a), 32'd0);
    check_eq("t6_rst_drop_b", 32'(drop_b), 32'd0);

    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
